lag_link_binder: RTL and testbench

Output-port link scheduler for the LAG router family. It maps flits from `NPL` physical lanes (PLs) onto `NL` aggregated global links using wormhole binding: a head flit claims a free link, and the lane keeps that link until its tail flit leaves. Each link has its own credit-based flow control. The block sits between the switch output of a LAG pl-router and that router's outgoing link bundle. It generalises a fixed two-link port to any lane count, link count and credit depth.

---
 rtl/lag_link_binder.sv | 218 +++++++++++++++++++++
 tb/tb_lag_link_binder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lag_link_binder.sv
// lag_link_binder: output-port link scheduler for the LAG router family.
// Maps flits from NPL physical lanes onto NL aggregated links with wormhole
// binding. A head flit claims a free link with credit, and the lane keeps that
// link until its tail flit leaves. Each link has its own credit counter.
// Optional feature macro: LAG_LINK_CREDIT_CHECK_EN. When defined, err[0]
// latches on credit overflow and err[1] latches on orphan body/tail flits.
// When undefined, err is tied to zero.
module lag_link_binder #(
    parameter int NPL     = 4,
    parameter int NL      = 2,
    parameter int FLIT_W  = 32,
    parameter int CREDITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NPL*FLIT_W-1:0] pl_flit_in,
    input  logic [NPL-1:0]        pl_valid,
    output logic [NPL-1:0]        pl_ready,
    output logic [NL*FLIT_W-1:0]  link_flit_out,
    output logic [NL-1:0]         link_valid,
    input  logic [NL-1:0]         link_credit_in,
    output logic [NL-1:0]         link_busy,
    output logic [1:0]            err
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int PW = (NPL > 1) ? $clog2(NPL) : 1;
    localparam int LW = (NL > 1) ? $clog2(NL) : 1;
    localparam int HB = FLIT_W - 1;  // head bit
    localparam int TB = FLIT_W - 2;  // tail bit

    typedef enum logic {
        LANE_IDLE,
        LANE_BOUND
    } lane_state_e;

    lane_state_e       lane_state_q [NPL];
    lane_state_e       lane_state_d [NPL];
    logic [LW-1:0]     lane_link_q  [NPL];
    logic [LW-1:0]     lane_link_d  [NPL];
    logic [NL-1:0]     owned_q, owned_d;
    logic [CW-1:0]     credit_q     [NL];
    logic [CW-1:0]     credit_d     [NL];
    logic [PW-1:0]     rr_pl_q, rr_pl_d;
    logic [LW-1:0]     rr_link_q, rr_link_d;
    logic [NL-1:0]     link_valid_q, link_valid_d;
    logic [FLIT_W-1:0] link_flit_q  [NL];
    logic [FLIT_W-1:0] link_flit_d  [NL];

    logic [FLIT_W-1:0] lane_flit [NPL];
    logic [NPL-1:0]    cand;
    logic              found_pl, found_link, grant;
    logic [PW-1:0]     win_pl;
    logic [LW-1:0]     win_link;

    // Unpack lane flits and mark idle lanes presenting a head as candidates.
    always_comb begin
        for (int i = 0; i < NPL; i++) begin
            lane_flit[i] = pl_flit_in[i*FLIT_W +: FLIT_W];
            cand[i]      = (lane_state_q[i] == LANE_IDLE) && pl_valid[i] && lane_flit[i][HB];
        end
    end

    // Round-robin pick of one candidate lane and the first free link with credit.
    always_comb begin
        // NOTE: every signal gets a default before any condition, so no path
        // leaves it unassigned and no latch is inferred.
        found_pl   = 1'b0;
        found_link = 1'b0;
        win_pl     = '0;
        win_link   = '0;
        for (int k = 0; k < NPL; k++) begin
            if (!found_pl && cand[(int'(rr_pl_q) + k) % NPL]) begin
                found_pl = 1'b1;
                win_pl   = PW'((int'(rr_pl_q) + k) % NPL);
            end
        end
        for (int k = 0; k < NL; k++) begin
            if (!found_link && !owned_q[(int'(rr_link_q) + k) % NL]
                && (credit_q[(int'(rr_link_q) + k) % NL] != '0)) begin
                found_link = 1'b1;
                win_link   = LW'((int'(rr_link_q) + k) % NL);
            end
        end
        grant = found_pl && found_link;
    end

    // Lane acceptance: bound lanes need credit, orphans are swallowed, and an
    // idle head is taken only in the cycle it wins allocation.
    always_comb begin
        pl_ready = '0;
        for (int i = 0; i < NPL; i++) begin
            if (lane_state_q[i] == LANE_BOUND) begin
                pl_ready[i] = pl_valid[i] && (credit_q[lane_link_q[i]] != '0);
            end else if (pl_valid[i] && !lane_flit[i][HB]) begin
                pl_ready[i] = 1'b1;
            end else if (grant && (win_pl == PW'(i))) begin
                pl_ready[i] = 1'b1;
            end
        end
    end

    // Next state: forward accepted flits, bind/unbind lanes, move pointers,
    // and update per-link credits.
    always_comb begin
        lane_state_d = lane_state_q;
        lane_link_d  = lane_link_q;
        owned_d      = owned_q;
        rr_pl_d      = rr_pl_q;
        rr_link_d    = rr_link_q;
        link_flit_d  = link_flit_q;
        link_valid_d = '0;
        credit_d     = credit_q;

        for (int i = 0; i < NPL; i++) begin
            if ((lane_state_q[i] == LANE_BOUND) && pl_ready[i]) begin
                link_valid_d[lane_link_q[i]] = 1'b1;
                link_flit_d[lane_link_q[i]]  = lane_flit[i];
                if (lane_flit[i][TB]) begin
                    lane_state_d[i]          = LANE_IDLE;
                    owned_d[lane_link_q[i]]  = 1'b0;
                end
            end
        end

        if (grant) begin
            link_valid_d[win_link] = 1'b1;
            link_flit_d[win_link]  = lane_flit[win_pl];
            rr_pl_d   = (win_pl == PW'(NPL - 1)) ? '0 : win_pl + 1'b1;
            rr_link_d = (win_link == LW'(NL - 1)) ? '0 : win_link + 1'b1;
            // A single-flit packet leaves the lane idle and the link free.
            if (!lane_flit[win_pl][TB]) begin
                lane_state_d[win_pl] = LANE_BOUND;
                lane_link_d[win_pl]  = win_link;
                owned_d[win_link]    = 1'b1;
            end
        end

        for (int l = 0; l < NL; l++) begin
            if (link_credit_in[l] && !link_valid_d[l]) begin
                if (credit_q[l] != CW'(CREDITS)) credit_d[l] = credit_q[l] + 1'b1;
            end else if (!link_credit_in[l] && link_valid_d[l]) begin
                credit_d[l] = credit_q[l] - 1'b1;
            end
        end
    end

    // State registers for lanes, links, credits and arbitration pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these per-lane/per-link arrays are a handful of flops, not
            // RAM, so they are all reset; a packet cut by reset must be resent.
            for (int i = 0; i < NPL; i++) begin
                lane_state_q[i] <= LANE_IDLE;
                lane_link_q[i]  <= '0;
            end
            for (int l = 0; l < NL; l++) begin
                credit_q[l]    <= CW'(CREDITS);
                link_flit_q[l] <= '0;
            end
            owned_q      <= '0;
            rr_pl_q      <= '0;
            rr_link_q    <= '0;
            link_valid_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            lane_state_q <= lane_state_d;
            lane_link_q  <= lane_link_d;
            credit_q     <= credit_d;
            link_flit_q  <= link_flit_d;
            owned_q      <= owned_d;
            rr_pl_q      <= rr_pl_d;
            rr_link_q    <= rr_link_d;
            link_valid_q <= link_valid_d;
        end
    end

    // Pack the registered link flits onto the output bus.
    always_comb begin
        for (int l = 0; l < NL; l++) begin
            link_flit_out[l*FLIT_W +: FLIT_W] = link_flit_q[l];
        end
    end

    assign link_valid = link_valid_q;
    assign link_busy  = owned_q;

`ifdef LAG_LINK_CREDIT_CHECK_EN
    logic [1:0] err_q, err_d;

    // Sticky error flags: overflow when a credit arrives at a full, idle link;
    // orphan when a non-head flit shows up on an idle lane.
    always_comb begin
        err_d = err_q;
        for (int l = 0; l < NL; l++) begin
            if (link_credit_in[l] && !link_valid_d[l] && (credit_q[l] == CW'(CREDITS))) begin
                err_d[0] = 1'b1;
            end
        end
        for (int i = 0; i < NPL; i++) begin
            if ((lane_state_q[i] == LANE_IDLE) && pl_valid[i] && !lane_flit[i][HB]) begin
                err_d[1] = 1'b1;
            end
        end
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= '0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = '0;
`endif

endmodule

// File: tb/tb_lag_link_binder.sv
// Directed self-checking bench for lag_link_binder (NPL=4, NL=2, CREDITS=4).
// Inputs change 1 ns after a rising edge; pl_ready is sampled 1 ns after the
// inputs settle, registered outputs 1 ns after the edge.
module tb_lag_link_binder;

    localparam int NPL = 4;
    localparam int NL  = 2;
    localparam int FW  = 32;
    localparam int CR  = 4;

`ifdef LAG_LINK_CREDIT_CHECK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NPL*FW-1:0] pl_flit_in;
    logic [NPL-1:0]    pl_valid;
    logic [NPL-1:0]    pl_ready;
    logic [NL*FW-1:0]  link_flit_out;
    logic [NL-1:0]     link_valid;
    logic [NL-1:0]     link_credit_in;
    logic [NL-1:0]     link_busy;
    logic [1:0]        err;

    int errors = 0;
    int checks = 0;

    lag_link_binder #(.NPL(NPL), .NL(NL), .FLIT_W(FW), .CREDITS(CR)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pl_flit_in    (pl_flit_in),
        .pl_valid      (pl_valid),
        .pl_ready      (pl_ready),
        .link_flit_out (link_flit_out),
        .link_valid    (link_valid),
        .link_credit_in(link_credit_in),
        .link_busy     (link_busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(input logic h, input logic t, input logic [29:0] p);
        return {h, t, p};
    endfunction

    task automatic drive(input int lane, input logic v, input logic [FW-1:0] f);
        pl_valid[lane]            = v;
        pl_flit_in[lane*FW +: FW] = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        pl_valid       = '0;
        pl_flit_in     = '0;
        link_credit_in = '0;
        rst_n          = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        pl_valid       = '0;
        pl_flit_in     = '0;
        link_credit_in = '0;
        rst_n          = 1'b1;
        #1;
        rst_n = 1'b0;
        #2;
        checks++; if (link_valid !== 2'b00) begin errors++; $display("FAIL rst_valid: got %b want 00", link_valid); end
        checks++; if (link_flit_out !== '0) begin errors++; $display("FAIL rst_flit: got %h want 0", link_flit_out); end
        checks++; if (link_busy !== 2'b00) begin errors++; $display("FAIL rst_busy: got %b want 00", link_busy); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL rst_err: got %b want 00", err); end
        checks++; if (pl_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b want 0000", pl_ready); end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single_packet();
        logic [FW-1:0] h, b, t;
        h = mk(1'b1, 1'b0, 30'h11);
        b = mk(1'b0, 1'b0, 30'h12);
        t = mk(1'b0, 1'b1, 30'h13);
        do_reset();
        drive(0, 1'b1, h); settle();
        checks++; if (pl_ready !== 4'b0001) begin errors++; $display("FAIL sp_ready_h: got %b want 0001", pl_ready); end
        step();
        checks++; if (link_valid !== 2'b01) begin errors++; $display("FAIL sp_valid_h: got %b want 01", link_valid); end
        checks++; if (link_flit_out[0 +: FW] !== h) begin errors++; $display("FAIL sp_flit_h: got %h want %h", link_flit_out[0 +: FW], h); end
        checks++; if (link_busy !== 2'b01) begin errors++; $display("FAIL sp_busy_1: got %b want 01", link_busy); end
        drive(0, 1'b1, b); settle();
        checks++; if (pl_ready !== 4'b0001) begin errors++; $display("FAIL sp_ready_b: got %b want 0001", pl_ready); end
        step();
        checks++; if (link_flit_out[0 +: FW] !== b) begin errors++; $display("FAIL sp_flit_b: got %h want %h", link_flit_out[0 +: FW], b); end
        checks++; if (link_busy !== 2'b01) begin errors++; $display("FAIL sp_busy_2: got %b want 01", link_busy); end
        drive(0, 1'b1, t);
        step();
        checks++; if (link_valid !== 2'b01) begin errors++; $display("FAIL sp_valid_t: got %b want 01", link_valid); end
        checks++; if (link_flit_out[0 +: FW] !== t) begin errors++; $display("FAIL sp_flit_t: got %h want %h", link_flit_out[0 +: FW], t); end
        drive(0, 1'b0, '0);
        step();
        checks++; if (link_valid !== 2'b00) begin errors++; $display("FAIL sp_valid_end: got %b want 00", link_valid); end
        checks++; if (link_busy !== 2'b00) begin errors++; $display("FAIL sp_busy_end: got %b want 00", link_busy); end
    endtask

    task automatic test_two_heads();
        logic [FW-1:0] h0, b0, t0, h1, t1;
        h0 = mk(1'b1, 1'b0, 30'h20);
        b0 = mk(1'b0, 1'b0, 30'h21);
        t0 = mk(1'b0, 1'b1, 30'h22);
        h1 = mk(1'b1, 1'b0, 30'h30);
        t1 = mk(1'b0, 1'b1, 30'h31);
        do_reset();
        drive(0, 1'b1, h0); drive(1, 1'b1, h1); settle();
        checks++; if (pl_ready !== 4'b0001) begin errors++; $display("FAIL th_ready_t: got %b want 0001", pl_ready); end
        step();
        checks++; if (link_busy !== 2'b01) begin errors++; $display("FAIL th_busy_1: got %b want 01", link_busy); end
        drive(0, 1'b1, b0); settle();
        checks++; if (pl_ready !== 4'b0011) begin errors++; $display("FAIL th_ready_t1: got %b want 0011", pl_ready); end
        step();
        checks++; if (link_valid !== 2'b11) begin errors++; $display("FAIL th_valid_2: got %b want 11", link_valid); end
        checks++; if (link_flit_out[0 +: FW] !== b0) begin errors++; $display("FAIL th_flit0: got %h want %h", link_flit_out[0 +: FW], b0); end
        checks++; if (link_flit_out[FW +: FW] !== h1) begin errors++; $display("FAIL th_flit1: got %h want %h", link_flit_out[FW +: FW], h1); end
        checks++; if (link_busy !== 2'b11) begin errors++; $display("FAIL th_busy_2: got %b want 11", link_busy); end
        drive(0, 1'b1, t0); drive(1, 1'b1, t1);
        step();
        checks++; if (link_flit_out !== {t1, t0}) begin errors++; $display("FAIL th_tails: got %h want %h", link_flit_out, {t1, t0}); end
        drive(0, 1'b0, '0); drive(1, 1'b0, '0);
        step();
        checks++; if (link_busy !== 2'b00) begin errors++; $display("FAIL th_busy_end: got %b want 00", link_busy); end
    endtask

    task automatic test_credit_stall();
        logic [FW-1:0] ht2, b4;
        ht2 = mk(1'b1, 1'b1, 30'h40);
        b4  = mk(1'b0, 1'b0, 30'h54);
        do_reset();
        for (int k = 0; k < CR; k++) begin
            drive(0, 1'b1, mk(k == 0, 1'b0, 30'(32'h50 + k))); settle();
            checks++; if (pl_ready[0] !== 1'b1) begin errors++; $display("FAIL cs_ready_%0d: got %b want 1", k, pl_ready[0]); end
            step();
        end
        drive(0, 1'b1, b4); drive(2, 1'b1, ht2); settle();
        checks++; if (pl_ready !== 4'b0100) begin errors++; $display("FAIL cs_stall: got %b want 0100", pl_ready); end
        step();
        checks++; if (link_valid !== 2'b10) begin errors++; $display("FAIL cs_other_link: got %b want 10", link_valid); end
        checks++; if (link_flit_out[FW +: FW] !== ht2) begin errors++; $display("FAIL cs_flit1: got %h want %h", link_flit_out[FW +: FW], ht2); end
        drive(2, 1'b0, '0);
        link_credit_in = 2'b01; settle();
        checks++; if (pl_ready !== 4'b0000) begin errors++; $display("FAIL cs_credit_cycle: got %b want 0000", pl_ready); end
        step();
        link_credit_in = 2'b00; settle();
        checks++; if (pl_ready !== 4'b0001) begin errors++; $display("FAIL cs_credit_use: got %b want 0001", pl_ready); end
        step();
        checks++; if (link_valid !== 2'b01) begin errors++; $display("FAIL cs_one_more: got %b want 01", link_valid); end
        checks++; if (link_flit_out[0 +: FW] !== b4) begin errors++; $display("FAIL cs_one_flit: got %h want %h", link_flit_out[0 +: FW], b4); end
        drive(0, 1'b1, mk(1'b0, 1'b0, 30'h55)); settle();
        checks++; if (pl_ready !== 4'b0000) begin errors++; $display("FAIL cs_stall_again: got %b want 0000", pl_ready); end
    endtask

    task automatic test_credit_edges();
        do_reset();
        drive(0, 1'b1, mk(1'b1, 1'b0, 30'h60)); step();
        drive(0, 1'b1, mk(1'b0, 1'b0, 30'h61)); step();
        drive(0, 1'b1, mk(1'b0, 1'b0, 30'h62)); link_credit_in = 2'b01; settle();
        checks++; if (pl_ready[0] !== 1'b1) begin errors++; $display("FAIL ce_same_ready: got %b want 1", pl_ready[0]); end
        step();
        link_credit_in = 2'b00;
        for (int k = 0; k < 2; k++) begin
            drive(0, 1'b1, mk(1'b0, 1'b0, 30'(32'h63 + k))); settle();
            checks++; if (pl_ready[0] !== 1'b1) begin errors++; $display("FAIL ce_after_same_%0d: got %b want 1", k, pl_ready[0]); end
            step();
        end
        drive(0, 1'b1, mk(1'b0, 1'b0, 30'h65)); settle();
        checks++; if (pl_ready[0] !== 1'b0) begin errors++; $display("FAIL ce_same_exhaust: got %b want 0", pl_ready[0]); end

        do_reset();
        link_credit_in = 2'b01;
        step();
        link_credit_in = 2'b00;
        checks++; if (err !== {1'b0, CHK_EN}) begin errors++; $display("FAIL ce_ovf_err: got %b want %b", err, {1'b0, CHK_EN}); end
        for (int k = 0; k < CR; k++) begin
            drive(0, 1'b1, mk(k == 0, 1'b0, 30'(32'h70 + k))); settle();
            checks++; if (pl_ready[0] !== 1'b1) begin errors++; $display("FAIL ce_sat_%0d: got %b want 1", k, pl_ready[0]); end
            step();
        end
        drive(0, 1'b1, mk(1'b0, 1'b0, 30'h7f)); settle();
        checks++; if (pl_ready[0] !== 1'b0) begin errors++; $display("FAIL ce_sat_exhaust: got %b want 0", pl_ready[0]); end
    endtask

    task automatic test_orphan();
        do_reset();
        drive(1, 1'b1, mk(1'b0, 1'b0, 30'h80)); settle();
        checks++; if (pl_ready !== 4'b0010) begin errors++; $display("FAIL or_ready: got %b want 0010", pl_ready); end
        step();
        drive(1, 1'b0, '0);
        checks++; if (link_valid !== 2'b00) begin errors++; $display("FAIL or_valid: got %b want 00", link_valid); end
        checks++; if (link_busy !== 2'b00) begin errors++; $display("FAIL or_busy: got %b want 00", link_busy); end
        checks++; if (err !== {CHK_EN, 1'b0}) begin errors++; $display("FAIL or_err: got %b want %b", err, {CHK_EN, 1'b0}); end
        step();
        checks++; if (err !== {CHK_EN, 1'b0}) begin errors++; $display("FAIL or_err_sticky: got %b want %b", err, {CHK_EN, 1'b0}); end
    endtask

    task automatic test_reset_mid();
        logic [FW-1:0] h3;
        h3 = mk(1'b1, 1'b0, 30'h93);
        do_reset();
        drive(0, 1'b1, mk(1'b1, 1'b0, 30'h90)); step();
        drive(0, 1'b1, mk(1'b0, 1'b0, 30'h91)); step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (link_valid !== 2'b00) begin errors++; $display("FAIL rm_valid: got %b want 00", link_valid); end
        checks++; if (link_flit_out !== '0) begin errors++; $display("FAIL rm_flit: got %h want 0", link_flit_out); end
        checks++; if (link_busy !== 2'b00) begin errors++; $display("FAIL rm_busy: got %b want 00", link_busy); end
        drive(0, 1'b0, '0);
        step();
        rst_n = 1'b1;
        drive(3, 1'b1, h3); settle();
        checks++; if (pl_ready !== 4'b1000) begin errors++; $display("FAIL rm_ready: got %b want 1000", pl_ready); end
        step();
        checks++; if (link_valid !== 2'b01) begin errors++; $display("FAIL rm_link0: got %b want 01", link_valid); end
        checks++; if (link_flit_out[0 +: FW] !== h3) begin errors++; $display("FAIL rm_flit0: got %h want %h", link_flit_out[0 +: FW], h3); end
        for (int k = 1; k < CR; k++) begin
            drive(3, 1'b1, mk(1'b0, 1'b0, 30'(32'h93 + k))); settle();
            checks++; if (pl_ready[3] !== 1'b1) begin errors++; $display("FAIL rm_credit_%0d: got %b want 1", k, pl_ready[3]); end
            step();
        end
        drive(3, 1'b1, mk(1'b0, 1'b0, 30'h9f)); settle();
        checks++; if (pl_ready[3] !== 1'b0) begin errors++; $display("FAIL rm_credit_end: got %b want 0", pl_ready[3]); end
        drive(3, 1'b0, '0);
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_two_heads();
        test_credit_stall();
        test_credit_edges();
        test_orphan();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
